// File: rtl/run_length_detector_if.sv
// Bundles the sample-side controls, serial data and the per-channel results
// of run_length_detector.
//   en      : sample enable
//   clr     : synchronous clear of run, hit counters and Moore z register
//   w       : serial data, bit c is channel c
//   z       : hit indication per channel
//   hit_cnt : per-channel saturating hit counters, channel c at [c*CNT_W +: CNT_W]
// master drives en/clr/w, slave (the detector) drives z/hit_cnt.
interface run_length_detector_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
);
  logic                      en;
  logic                      clr;
  logic [CHANNELS-1:0]       w;
  logic [CHANNELS-1:0]       z;
  logic [CHANNELS*CNT_W-1:0] hit_cnt;

  modport master (output en, clr, w, input z, hit_cnt);
  modport slave  (input en, clr, w, output z, hit_cnt);
endinterface

// File: rtl/run_length_detector.sv
// Multi-channel detector of runs of consecutive 1s on serial inputs.
// A channel hits when it sees RUN_LEN consecutive 1s (enabled samples only).
// Output is either Mealy (combinational from w) or Moore (registered, +1 cycle).
// With OVERLAP=1 every further 1 after a full run is another hit; with
// OVERLAP=0 the run restarts after each hit. Each channel keeps a saturating
// hit counter.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : run_length_detector_if slave (en, clr, w in; z, hit_cnt out)
module run_length_detector #(
  parameter int CHANNELS = 4,
  parameter int RUN_LEN  = 2,
  parameter int MOORE    = 0,
  parameter int OVERLAP  = 1,
  parameter int CNT_W    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  run_length_detector_if.slave   bus
);

  localparam int               RUN_W    = (RUN_LEN > 1) ? $clog2(RUN_LEN) : 1;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [CHANNELS-1:0]       hit;
  logic [CHANNELS-1:0]       z_o;
  logic [CHANNELS*CNT_W-1:0] cnt_flat;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [RUN_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             z_q, z_d;

    // For RUN_LEN=1 run_q is stuck at 0 == RUN_LAST, so hit reduces to en & w.
    assign hit[c] = bus.en & bus.w[c] & (run_q == RUN_LAST);

    always_comb begin
      run_d = run_q;
      cnt_d = cnt_q;
      z_d   = z_q;
      if (bus.clr) begin
        // clr wins over a same-cycle hit: nothing is counted
        run_d = '0;
        cnt_d = '0;
        z_d   = 1'b0;
      end else if (bus.en) begin
        z_d = hit[c];
        if (!bus.w[c]) begin
          run_d = '0;
        end else if (hit[c]) begin
          run_d = (OVERLAP != 0) ? run_q : '0;
        end else begin
          run_d = run_q + 1'b1;
        end
        if (hit[c] && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        run_q <= '0;
        cnt_q <= '0;
        z_q   <= 1'b0;
      end else begin
        run_q <= run_d;
        cnt_q <= cnt_d;
        z_q   <= z_d;
      end
    end

    // Gate with reset so z reads 0 during reset even when RUN_LEN=1 in Mealy mode.
    assign z_o[c] = reset ? 1'b0 : ((MOORE != 0) ? z_q : hit[c]);
    assign cnt_flat[c*CNT_W +: CNT_W] = cnt_q;
  end

  assign bus.z       = z_o;
  assign bus.hit_cnt = cnt_flat;

endmodule

// File: tb/tb_run_length_detector.sv
// Directed bench for run_length_detector using four instances with different
// parameter sets: default Mealy, non-overlap RUN_LEN=3, Moore, and CNT_W=2.
module tb_run_length_detector;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  run_length_detector_if #(.CHANNELS(4), .CNT_W(8)) if_def ();
  run_length_detector_if #(.CHANNELS(4), .CNT_W(8)) if_nov ();
  run_length_detector_if #(.CHANNELS(4), .CNT_W(8)) if_moo ();
  run_length_detector_if #(.CHANNELS(4), .CNT_W(2)) if_sat ();

  run_length_detector #(.CHANNELS(4), .RUN_LEN(2), .MOORE(0), .OVERLAP(1), .CNT_W(8))
    u_def (.clk(clk), .reset(reset), .bus(if_def));
  run_length_detector #(.CHANNELS(4), .RUN_LEN(3), .MOORE(0), .OVERLAP(0), .CNT_W(8))
    u_nov (.clk(clk), .reset(reset), .bus(if_nov));
  run_length_detector #(.CHANNELS(4), .RUN_LEN(2), .MOORE(1), .OVERLAP(1), .CNT_W(8))
    u_moo (.clk(clk), .reset(reset), .bus(if_moo));
  run_length_detector #(.CHANNELS(4), .RUN_LEN(2), .MOORE(0), .OVERLAP(1), .CNT_W(2))
    u_sat (.clk(clk), .reset(reset), .bus(if_sat));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic t1_w [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic t1_z [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic t2_w [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic t2_z [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic t3_w [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic t3_zb[4] = '{1'b0, 1'b0, 1'b0, 1'b1};  // z just before each edge
  logic t3_za[4] = '{1'b0, 1'b0, 1'b1, 1'b0};  // z just after each edge

  initial begin
    if_def.en = 1'b0; if_def.clr = 1'b0; if_def.w = '0;
    if_nov.en = 1'b0; if_nov.clr = 1'b0; if_nov.w = '0;
    if_moo.en = 1'b0; if_moo.clr = 1'b0; if_moo.w = '0;
    if_sat.en = 1'b0; if_sat.clr = 1'b0; if_sat.w = '0;
    #12;
    check("rst_z_def",   32'(if_def.z), 32'h0);
    check("rst_cnt_def", 32'(if_def.hit_cnt), 32'h0);
    check("rst_z_moo",   32'(if_moo.z), 32'h0);
    reset = 1'b0;
    tick();

    // Mealy, RUN_LEN=2, overlap
    if_def.en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if_def.w[0] = t1_w[i];
      #1;
      check($sformatf("t1_z0[%0d]", i), 32'(if_def.z[0]), 32'(t1_z[i]));
      tick();
    end
    check("t1_cnt0", 32'(if_def.hit_cnt[7:0]), 32'd3);

    // Non-overlap, RUN_LEN=3 on channel 1
    if_nov.en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if_nov.w[1] = t2_w[i];
      #1;
      check($sformatf("t2_z1[%0d]", i), 32'(if_nov.z[1]), 32'(t2_z[i]));
      tick();
    end
    check("t2_cnt1", 32'(if_nov.hit_cnt[15:8]), 32'd2);

    // Moore on channel 2: z only changes after edges, never from w directly
    if_moo.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if_moo.w[2] = t3_w[i];
      #1;
      check($sformatf("t3_zpre[%0d]", i), 32'(if_moo.z[2]), 32'(t3_zb[i]));
      tick();
      check($sformatf("t3_zpost[%0d]", i), 32'(if_moo.z[2]), 32'(t3_za[i]));
    end
    check("t3_cnt2", 32'(if_moo.hit_cnt[23:16]), 32'd1);

    // CNT_W=2 saturation, then clr
    if_sat.en = 1'b1;
    if_sat.w[3] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 3) check("t4_cnt_e3", 32'(if_sat.hit_cnt[7:6]), 32'd2);
      if (i == 4) check("t4_cnt_e4", 32'(if_sat.hit_cnt[7:6]), 32'd3);
    end
    check("t4_cnt_sat", 32'(if_sat.hit_cnt[7:6]), 32'd3);
    if_sat.clr = 1'b1;
    #1;
    check("t4_z_clr", 32'(if_sat.z[3]), 32'd1);
    tick();
    check("t4_cnt_clr", 32'(if_sat.hit_cnt[7:6]), 32'd0);
    if_sat.clr = 1'b0;
    #1;
    check("t4_z_first1", 32'(if_sat.z[3]), 32'd0);
    tick();
    check("t4_cnt_first1", 32'(if_sat.hit_cnt[7:6]), 32'd0);
    check("t4_z_second1", 32'(if_sat.z[3]), 32'd1);
    tick();
    check("t4_cnt_second1", 32'(if_sat.hit_cnt[7:6]), 32'd1);

    // en toggling on the default instance
    if_def.clr = 1'b1; if_def.w[0] = 1'b0;
    tick();
    if_def.clr = 1'b0;
    check("t5_cnt_clr", 32'(if_def.hit_cnt[7:0]), 32'd0);
    if_def.w[0] = 1'b1;
    #1;
    check("t5_z_arm", 32'(if_def.z[0]), 32'd0);
    tick();
    if_def.en = 1'b0; if_def.w[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("t5_z_dis[%0d]", i), 32'(if_def.z[0]), 32'd0);
      tick();
    end
    if_def.w[0] = 1'b1;
    #1;
    check("t5_z_dis_w1", 32'(if_def.z[0]), 32'd0);
    tick();
    check("t5_cnt_dis", 32'(if_def.hit_cnt[7:0]), 32'd0);
    if_def.en = 1'b1;
    #1;
    check("t5_z_reen", 32'(if_def.z[0]), 32'd1);
    tick();
    check("t5_cnt_reen", 32'(if_def.hit_cnt[7:0]), 32'd1);

    // Async reset between edges with run[0]=1
    #1;
    check("t6_z_prerst", 32'(if_def.z[0]), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_z_rst", 32'(if_def.z[0]), 32'd0);
    check("t6_cnt_rst", 32'(if_def.hit_cnt[7:0]), 32'd0);
    #1;
    reset = 1'b0;
    #1;
    check("t6_z_first1", 32'(if_def.z[0]), 32'd0);
    tick();
    check("t6_cnt_first1", 32'(if_def.hit_cnt[7:0]), 32'd0);
    #1;
    check("t6_z_second1", 32'(if_def.z[0]), 32'd1);
    tick();
    check("t6_cnt_second1", 32'(if_def.hit_cnt[7:0]), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
